// File: rtl/vga_logo_scan.sv
// Raster scan source for the logo painters: pixel/line counters, bouncing scroll offset,
// and a registered colour/sync stage that lines hsync/vsync up with rgb.
module vga_logo_scan #(
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter int          DELT_MAX        = 100,
    parameter int          FRAMES_PER_STEP = 2,
    parameter logic [7:0]  FG_RGB          = 8'hFF,
    parameter logic [7:0]  BG_RGB          = 8'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        hit,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        enble,
    output logic [10:0] delt,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb
);

    localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] DMAX_W   = 11'(DELT_MAX);
    localparam int          FC_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

    typedef enum logic {UP, DOWN} dir_t;

    logic [10:0]     x_nxt, y_nxt;
    logic            frame_end;
    logic            hs_raw, vs_raw;
    dir_t            dir, dir_nxt;
    logic [10:0]     delt_nxt;
    logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;

    // ---- stage p0: scan counters, enble follows the next-state coordinates
    always_comb begin
        x_nxt     = x + 11'd1;
        y_nxt     = y;
        frame_end = 1'b0;
        if (x == H_LAST) begin
            x_nxt = 11'd0;
            if (y == V_LAST) begin
                y_nxt     = 11'd0;
                frame_end = 1'b1;
            end else begin
                y_nxt = y + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x     <= 11'd0;
            y     <= 11'd0;
            enble <= 1'b0;
        end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            enble <= (x_nxt < H_ACT_W) && (y_nxt < V_ACT_W);
        end
    end

    // Scroll offset only moves on the frame wrap so a whole frame sees one delt.
    always_comb begin
        dir_nxt       = dir;
        delt_nxt      = delt;
        frame_cnt_nxt = frame_cnt;
        if (frame_end && run) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt_nxt = '0;
                case (dir)
                    UP: begin
                        if (delt >= DMAX_W - 11'd1) begin
                            delt_nxt = DMAX_W;
                            dir_nxt  = DOWN;
                        end else begin
                            delt_nxt = delt + 11'd1;
                        end
                    end
                    DOWN: begin
                        if (delt <= 11'd1) begin
                            delt_nxt = 11'd0;
                            dir_nxt  = UP;
                        end else begin
                            delt_nxt = delt - 11'd1;
                        end
                    end
                    default: begin
                        delt_nxt = 11'd0;
                        dir_nxt  = UP;
                    end
                endcase
            end else begin
                frame_cnt_nxt = frame_cnt + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir       <= UP;
            delt      <= 11'd0;
            frame_cnt <= '0;
        end else begin
            dir       <= dir_nxt;
            delt      <= delt_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    // ---- stage p1: colour from painter hit, syncs delayed to match
    always_comb begin
        hs_raw = !((x >= HS_FIRST) && (x <= HS_LAST));
        vs_raw = !((y >= VS_FIRST) && (y <= VS_LAST));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 8'h00;
        end else begin
            hsync <= hs_raw;
            vsync <= vs_raw;
            rgb   <= enble ? (hit ? FG_RGB : BG_RGB) : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_logo_scan.sv
// Randomised bench for vga_logo_scan on a shrunken raster, checked against a cycle-count model.
module tb_vga_logo_scan;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 8, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int DMAX = 5, FPS = 2;
    localparam logic [7:0] FG = 8'hFF, BG = 8'h03;

    logic        clk = 1'b0;
    logic        rst, run, hit;
    logic [10:0] x, y, delt;
    logic        enble, hsync, vsync;
    logic [7:0]  rgb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_logo_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .DELT_MAX(DMAX), .FRAMES_PER_STEP(FPS), .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .hit(hit),
        .x(x), .y(y), .enble(enble), .delt(delt),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    // Reference: position is elapsed cycles mod line/frame; delt is a triangle wave
    // of the number of steps earned by frames that ended with run=1.
    int         m_t, m_nrun;
    bit         m_fresh;
    logic [7:0] m_rgb;
    logic       m_hs, m_vs;
    int         ex_x, ex_y, ex_steps, ex_phase, ex_delt;
    logic       ex_enble;

    assign ex_x     = m_t % HT;
    assign ex_y     = (m_t / HT) % VT;
    assign ex_enble = !m_fresh && (ex_x < HA) && (ex_y < VA);
    assign ex_steps = m_nrun / FPS;
    assign ex_phase = ex_steps % (2 * DMAX);
    assign ex_delt  = (ex_phase <= DMAX) ? ex_phase : (2 * DMAX - ex_phase);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t     <= 0;
            m_nrun  <= 0;
            m_fresh <= 1'b1;
            m_rgb   <= 8'h00;
            m_hs    <= 1'b1;
            m_vs    <= 1'b1;
        end else begin
            m_fresh <= 1'b0;
            m_rgb   <= ex_enble ? (hit ? FG : BG) : 8'h00;
            m_hs    <= !(ex_x >= HA + HF && ex_x < HA + HF + HS);
            m_vs    <= !(ex_y >= VA + VF && ex_y < VA + VF + VS);
            if (ex_x == HT - 1 && ex_y == VT - 1 && run) m_nrun <= m_nrun + 1;
            m_t <= m_t + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; hit = 1'b0;
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_chk++; if (x !== 11'd0)    begin n_fail++; $display("FAIL reset_x got %0d want 0", x); end
        n_chk++; if (y !== 11'd0)    begin n_fail++; $display("FAIL reset_y got %0d want 0", y); end
        n_chk++; if (enble !== 1'b0) begin n_fail++; $display("FAIL reset_enble got %b want 0", enble); end
        n_chk++; if (delt !== 11'd0) begin n_fail++; $display("FAIL reset_delt got %0d want 0", delt); end
        n_chk++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", hsync); end
        n_chk++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", vsync); end
        n_chk++; if (rgb !== 8'h00)  begin n_fail++; $display("FAIL reset_rgb got %h want 00", rgb); end
    endtask

    task automatic test_line_timing();
        int lo_len = 0, last_fall = -1, vs_lo = 0;
        logic prev_hs = 1'b1;
        rst = 1'b1; hit = 1'b1; run = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            n_chk++; if (x !== 11'(ex_x))   begin n_fail++; $display("FAIL line_x c=%0d got %0d want %0d", c, x, ex_x); end
            n_chk++; if (y !== 11'(ex_y))   begin n_fail++; $display("FAIL line_y c=%0d got %0d want %0d", c, y, ex_y); end
            n_chk++; if (enble !== ex_enble) begin n_fail++; $display("FAIL line_enble c=%0d got %b want %b", c, enble, ex_enble); end
            n_chk++; if (rgb !== m_rgb)      begin n_fail++; $display("FAIL line_rgb c=%0d got %h want %h", c, rgb, m_rgb); end
            n_chk++; if (hsync !== m_hs)     begin n_fail++; $display("FAIL line_hsync c=%0d got %b want %b", c, hsync, m_hs); end
            n_chk++; if (vsync !== m_vs)     begin n_fail++; $display("FAIL line_vsync c=%0d got %b want %b", c, vsync, m_vs); end
            if (hsync === 1'b0) lo_len++;
            else if (lo_len != 0) begin
                n_chk++; if (lo_len != HS) begin n_fail++; $display("FAIL hsync_width got %0d want %0d", lo_len, HS); end
                lo_len = 0;
            end
            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                if (last_fall >= 0) begin
                    n_chk++; if (c - last_fall != HT) begin n_fail++; $display("FAIL line_period got %0d want %0d", c - last_fall, HT); end
                end
                last_fall = c;
            end
            prev_hs = hsync;
            if (vsync === 1'b0) vs_lo++;
        end
        n_chk++; if (vs_lo != 2 * VS * HT) begin n_fail++; $display("FAIL vsync_low_cycles got %0d want %0d", vs_lo, 2 * VS * HT); end
    endtask

    task automatic test_colour_gating();
        bit found = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            if (ex_x == HA + 1) found = 1;
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL gate_wait_blank got timeout want x=%0d", HA + 1); end
        hit = 1'b1;
        @(negedge clk);
        n_chk++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL gate_blank_rgb got %h want 00", rgb); end
        found = 0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clk);
            if (ex_x == 2 && ex_y == 2) found = 1;
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL gate_wait_active got timeout want x=2,y=2"); end
        hit = 1'b0;
        @(negedge clk);
        n_chk++; if (rgb !== BG) begin n_fail++; $display("FAIL gate_bg_rgb got %h want %h", rgb, BG); end
        hit = 1'b1;
        @(negedge clk);
        n_chk++; if (rgb !== FG) begin n_fail++; $display("FAIL gate_fg_rgb got %h want %h", rgb, FG); end
    endtask

    task automatic test_bounce();
        logic [10:0] prev;
        int max_seen = 0;
        run = 1'b1;
        prev = delt;
        for (int c = 0; c < 22 * FRAME; c++) begin
            @(negedge clk);
            n_chk++; if (delt !== 11'(ex_delt)) begin n_fail++; $display("FAIL bounce_delt c=%0d got %0d want %0d", c, delt, ex_delt); end
            n_chk++; if (delt !== prev && (ex_x != 0 || ex_y != 0)) begin
                n_fail++; $display("FAIL bounce_change_pos got change at x=%0d y=%0d want only at 0,0", ex_x, ex_y);
            end
            n_chk++; if (rgb !== m_rgb) begin n_fail++; $display("FAIL bounce_rgb c=%0d got %h want %h", c, rgb, m_rgb); end
            if (int'(delt) > max_seen) max_seen = int'(delt);
            prev = delt;
            hit = 1'($urandom);
        end
        n_chk++; if (max_seen != DMAX) begin n_fail++; $display("FAIL bounce_peak got %0d want %0d", max_seen, DMAX); end
    endtask

    task automatic test_freeze();
        bit found = 0;
        run = 1'b1;
        for (int c = 0; c < 4 * FPS * DMAX * FRAME && !found; c++) begin
            @(negedge clk);
            if (ex_delt == 2 && ex_x == HT / 2 && ex_y == 1 + int'($urandom_range(0, VT - 3))) found = 1;
            hit = 1'($urandom);
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL freeze_wait got timeout want delt=2"); end
        run = 1'b0;
        for (int c = 0; c < 3 * FRAME + HT; c++) begin
            @(negedge clk);
            n_chk++; if (delt !== 11'd2) begin n_fail++; $display("FAIL freeze_hold c=%0d got %0d want 2", c, delt); end
            n_chk++; if (delt !== 11'(ex_delt)) begin n_fail++; $display("FAIL freeze_model c=%0d got %0d want %0d", c, delt, ex_delt); end
            hit = 1'($urandom);
        end
        run = 1'b1;
        for (int c = 0; c < 6 * FRAME; c++) begin
            @(negedge clk);
            n_chk++; if (delt !== 11'(ex_delt)) begin n_fail++; $display("FAIL resume_delt c=%0d got %0d want %0d", c, delt, ex_delt); end
            hit = 1'($urandom);
        end
    endtask

    task automatic test_midframe_reset();
        bit found = 0;
        run = 1'b1;
        for (int c = 0; c < 30 * FRAME && !found; c++) begin
            @(negedge clk);
            if (ex_delt == DMAX && ex_x == 7 && ex_y == 4) found = 1;
            hit = 1'($urandom);
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL mid_wait got timeout want delt=%0d", DMAX); end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (x !== 11'd0)    begin n_fail++; $display("FAIL mid_x got %0d want 0", x); end
        n_chk++; if (y !== 11'd0)    begin n_fail++; $display("FAIL mid_y got %0d want 0", y); end
        n_chk++; if (enble !== 1'b0) begin n_fail++; $display("FAIL mid_enble got %b want 0", enble); end
        n_chk++; if (delt !== 11'd0) begin n_fail++; $display("FAIL mid_delt got %0d want 0", delt); end
        n_chk++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL mid_hsync got %b want 1", hsync); end
        n_chk++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL mid_vsync got %b want 1", vsync); end
        n_chk++; if (rgb !== 8'h00)  begin n_fail++; $display("FAIL mid_rgb got %h want 00", rgb); end
        repeat (3) @(negedge clk);
        rst = 1'b1; hit = 1'b1;
        @(negedge clk);
        n_chk++; if (x !== 11'd1)    begin n_fail++; $display("FAIL restart_x got %0d want 1", x); end
        n_chk++; if (y !== 11'd0)    begin n_fail++; $display("FAIL restart_y got %0d want 0", y); end
        n_chk++; if (delt !== 11'd0) begin n_fail++; $display("FAIL restart_delt got %0d want 0", delt); end
        n_chk++; if (enble !== 1'b1) begin n_fail++; $display("FAIL restart_enble got %b want 1", enble); end
        n_chk++; if (rgb !== 8'h00)  begin n_fail++; $display("FAIL restart_rgb got %h want 00", rgb); end
        repeat (FPS * FRAME) @(negedge clk);
        n_chk++; if (delt !== 11'd1) begin n_fail++; $display("FAIL restart_dir_up got %0d want 1", delt); end
        n_chk++; if (delt !== 11'(ex_delt)) begin n_fail++; $display("FAIL restart_model got %0d want %0d", delt, ex_delt); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_colour_gating();
        test_bounce();
        test_freeze();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
